// File: rtl/booth_pkg.sv
// Shared encodings for the sign-representation converter family.
package booth_pkg;

  localparam logic MODE_2C2SM = 1'b0;
  localparam logic MODE_SM22C = 1'b1;

endpackage

// File: rtl/twoc_negate.sv
// Combinational negate/saturate datapath between the S1 and S2 registers.
module twoc_negate
  import booth_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] data,
  input  logic             mode,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             negz
);

  logic             sign;
  logic             mag_zero;
  logic [WIDTH-1:0] mag_ext;
  logic [WIDTH-1:0] neg_in;
  logic [WIDTH-1:0] neg_mag;

  assign sign     = data[WIDTH-1];
  assign mag_zero = (data[WIDTH-2:0] == '0);
  assign mag_ext  = {1'b0, data[WIDTH-2:0]};
  assign neg_in   = ~data + WIDTH'(1);
  assign neg_mag  = ~mag_ext + WIDTH'(1);

  // A sign bit with zero low bits is the most-negative value in 2C and -0 in SM.
  always_comb begin
    result = data;
    ovf    = 1'b0;
    negz   = 1'b0;
    if (sign) begin
      if (mode == MODE_2C2SM) begin
        if (mag_zero) begin
          result = '1;
          ovf    = 1'b1;
        end else begin
          result = {1'b1, neg_in[WIDTH-2:0]};
        end
      end else begin
        if (mag_zero) begin
          result = '0;
          negz   = 1'b1;
        end else begin
          result = neg_mag;
        end
      end
    end
  end

endmodule

// File: rtl/twoc_sm_conv.sv
// Two-stage valid/ready converter between two's complement and sign-magnitude.
module twoc_sm_conv
  import booth_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             out_negz,
  output logic [CNT_W-1:0] ovf_count
);

  logic             rdy_en;
  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;
  logic             s1_mode;
  logic             s1_adv;
  logic             s2_adv;
  logic             in_fire;
  logic [WIDTH-1:0] conv_data;
  logic             conv_ovf;
  logic             conv_negz;

  assign s2_adv  = !out_valid || out_ready;
  assign s1_adv  = !s1_valid || s2_adv;
  // rdy_en keeps in_ready low through reset and releases it one edge later.
  assign in_ready = rdy_en && s1_adv;
  assign in_fire  = in_valid && in_ready;

  twoc_negate #(
    .WIDTH(WIDTH)
  ) u_negate (
    .data  (s1_data),
    .mode  (s1_mode),
    .result(conv_data),
    .ovf   (conv_ovf),
    .negz  (conv_negz)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdy_en    <= 1'b0;
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_mode   <= MODE_2C2SM;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      out_negz  <= 1'b0;
      ovf_count <= '0;
    end else begin
      rdy_en <= 1'b1;

      if (s1_adv) begin
        s1_valid <= in_fire;
        if (in_fire) begin
          s1_data <= in_data;
          s1_mode <= in_mode;
        end
      end

      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_data <= conv_data;
          out_ovf  <= conv_ovf;
          out_negz <= conv_negz;
        end
      end

      if (out_valid && out_ready && out_ovf && (ovf_count != '1)) begin
        ovf_count <= ovf_count + CNT_W'(1);
      end
    end
  end

endmodule
